// File: rtl/produto_escalar_ctrl.sv
// Sequencer for the produto_escalar accelerator.
// It accepts a command, fetches eight a-words and then eight b-words from a
// sync-read memory, and pulses start to the accelerator. It then waits for
// done or for a timeout, and returns the result on a valid/ready response port.
module produto_escalar_ctrl #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr_a,
  input  logic [AW-1:0] cmd_addr_b,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rd_data,
  output logic [255:0]  acc_a,
  output logic [255:0]  acc_b,
  output logic          acc_start,
  input  logic          acc_done,
  input  logic [63:0]   acc_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [63:0]   rsp_result,
  output logic          rsp_timeout,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_a_q, base_a_d;
  logic [AW-1:0]   base_b_q, base_b_d;
  logic [4:0]      fc_q, fc_d;         // FETCH cycle number, 1..17
  logic [TW-1:0]   tmo_q, tmo_d;       // cycles spent in WAIT
  logic [255:0]    acc_a_q, acc_a_d;
  logic [255:0]    acc_b_q, acc_b_d;
  logic [63:0]     rsp_result_q, rsp_result_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  // Read index (cycles 1..16) and capture index (cycles 2..17). Bit 3 selects
  // vector b. Bits 2:0 select the element.
  logic [3:0]      rd_idx;
  logic [3:0]      cap_idx;
  logic [TW-1:0]   tmo_inc;

  assign rd_idx  = 4'(fc_q - 5'd1);
  assign cap_idx = 4'(fc_q - 5'd2);
  assign tmo_inc = tmo_q + TW'(1);

  // State and datapath registers. Reset drops any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      base_a_q      <= '0;
      base_b_q      <= '0;
      fc_q          <= '0;
      tmo_q         <= '0;
      acc_a_q       <= '0;
      acc_b_q       <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_a_q      <= base_a_d;
      base_b_q      <= base_b_d;
      fc_q          <= fc_d;
      tmo_q         <= tmo_d;
      acc_a_q       <= acc_a_d;
      acc_b_q       <= acc_b_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state logic and decoded outputs. Every register holds unless a state changes it.
  always_comb begin
    state_d       = state_q;
    base_a_d      = base_a_q;
    base_b_d      = base_b_q;
    fc_d          = fc_q;
    tmo_d         = tmo_q;
    acc_a_d       = acc_a_q;
    acc_b_d       = acc_b_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    cmd_ready     = 1'b0;
    mem_rd_en     = 1'b0;
    mem_addr      = '0;
    acc_start     = 1'b0;
    rsp_valid     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          base_a_d = cmd_addr_a;
          base_b_d = cmd_addr_b;
          fc_d     = 5'd1;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        // Reads happen in cycles 1..16. The address add wraps at 2^AW.
        if (fc_q <= 5'd16) begin
          mem_rd_en = 1'b1;
          mem_addr  = (rd_idx[3] ? base_b_q : base_a_q) + AW'(rd_idx[2:0]);
        end
        // Read data returns one cycle after its strobe.
        if (fc_q >= 5'd2) begin
          if (cap_idx[3]) acc_b_d[32*cap_idx[2:0] +: 32] = mem_rd_data;
          else            acc_a_d[32*cap_idx[2:0] +: 32] = mem_rd_data;
        end
        fc_d = fc_q + 5'd1;
        if (fc_q == 5'd17) state_d = S_START;
      end

      S_START: begin
        acc_start = 1'b1;
        tmo_d     = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        // If done and the timeout limit arrive in the same cycle, done wins.
        if (acc_done) begin
          rsp_result_d  = acc_result;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TW'(TIMEOUT)) begin
            rsp_result_d  = '0;
            rsp_timeout_d = 1'b1;
            state_d       = S_RESP;
          end
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign acc_a       = acc_a_q;
  assign acc_b       = acc_b_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_produto_escalar_ctrl.sv
// Directed bench for produto_escalar_ctrl. It provides a sync memory model and
// a simple accelerator model. A second instance with AW=4 covers address wrap.
module tb_produto_escalar_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 1: AW=8, TIMEOUT=16
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [7:0]   cmd_addr_a = '0, cmd_addr_b = '0;
  logic         mem_rd_en;
  logic [7:0]   mem_addr;
  logic [31:0]  mem_rd_data = '0;
  logic [255:0] acc_a, acc_b;
  logic         acc_start, acc_done;
  logic [63:0]  acc_result;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
  logic [63:0]  rsp_result;

  produto_escalar_ctrl #(.AW(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .acc_a(acc_a), .acc_b(acc_b), .acc_start(acc_start),
    .acc_done(acc_done), .acc_result(acc_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  // Instance 2: AW=4, accelerator never answers
  logic         cmd_valid2 = 1'b0, cmd_ready2;
  logic [3:0]   cmd_addr_a2 = '0, cmd_addr_b2 = '0;
  logic         mem_rd_en2;
  logic [3:0]   mem_addr2;
  logic [31:0]  mem_rd_data2 = '0;
  logic [255:0] acc_a2, acc_b2;
  logic         acc_start2;
  logic         acc_done2 = 1'b0;
  logic [63:0]  acc_result2 = '0;
  logic         rsp_valid2, rsp_timeout2, busy2;
  logic         rsp_ready2 = 1'b1;
  logic [63:0]  rsp_result2;

  produto_escalar_ctrl #(.AW(4), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_addr_a(cmd_addr_a2), .cmd_addr_b(cmd_addr_b2),
    .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_rd_data(mem_rd_data2),
    .acc_a(acc_a2), .acc_b(acc_b2), .acc_start(acc_start2),
    .acc_done(acc_done2), .acc_result(acc_result2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_result(rsp_result2), .rsp_timeout(rsp_timeout2), .busy(busy2)
  );

  // Memory model: synchronous read
  logic [31:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // Accelerator model: done is raised in the 3rd cycle after start
  logic       never_done = 1'b0, spur_done = 1'b0, pend;
  logic [1:0] dly;
  always @(posedge clk or posedge rst) begin
    if (rst) begin pend <= 1'b0; dly <= '0; end
    else if (acc_start) begin pend <= 1'b1; dly <= 2'd2; end
    else if (pend) begin
      if (dly == 2'd0) pend <= 1'b0;
      else dly <= dly - 2'd1;
    end
  end
  assign acc_done = (pend && dly == 2'd0 && !never_done) || spur_done;

  function automatic logic [63:0] dotp(input logic [255:0] a, input logic [255:0] b);
    longint s;
    logic signed [31:0] x, y;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      x = a[32*i +: 32];
      y = b[32*i +: 32];
      s += longint'(x) * longint'(y);
    end
    return s;
  endfunction
  assign acc_result = dotp(acc_a, acc_b);

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one command end to end and checks the timing and the response.
  task automatic run_cmd(input logic [7:0] ba, input logic [7:0] bb, input int hold,
                         input logic [63:0] exp_res, input logic exp_tmo, input int exp_k);
    int k, st_n, st_k, addr_err, hold_err, lane_err, late_rd;
    logic seen;
    logic [7:0] ea, ia, ib;
    logic [63:0] r0;
    k = 0; st_n = 0; st_k = -1; addr_err = 0; hold_err = 0; lane_err = 0; late_rd = 0;
    seen = 1'b0;
    @(negedge clk);
    chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_addr_a = ba; cmd_addr_b = bb;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 1) cmd_valid = 1'b0;
      if (acc_start) begin st_n++; st_k = k; end
      if (k <= 16) begin
        ea = (k <= 8) ? ba + 8'(k - 1) : bb + 8'(k - 9);
        if (mem_rd_en !== 1'b1 || mem_addr !== ea) addr_err++;
      end else if (mem_rd_en) addr_err++;
      if (rsp_valid) seen = 1'b1;
    end
    chk("rsp_seen", {63'd0, seen}, 64'd1);
    chk("rsp_cycle", 64'(k), 64'(exp_k));
    chk("start_count", 64'(st_n), 64'd1);
    chk("start_cycle", 64'(st_k), 64'd18);
    chk("fetch_addr_errs", 64'(addr_err), 64'd0);
    chk("rsp_result", rsp_result, exp_res);
    chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, exp_tmo});
    for (int i = 0; i < 8; i++) begin
      ia = ba + 8'(i);
      ib = bb + 8'(i);
      if (acc_a[32*i +: 32] !== mem[ia] || acc_b[32*i +: 32] !== mem[ib]) lane_err++;
    end
    chk("lane_errs", 64'(lane_err), 64'd0);
    r0 = rsp_result;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_addr_a = 8'h20; cmd_addr_b = 8'h28;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== r0 || cmd_ready !== 1'b0) hold_err++;
    end
    if (hold > 0) chk("hold_errs", 64'(hold_err), 64'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_state", {61'd0, rsp_valid, cmd_ready, busy}, 64'b010);
    repeat (3) begin
      @(negedge clk);
      if (mem_rd_en || busy) late_rd++;
    end
    chk("no_extra_cmd", 64'(late_rd), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  ba, bb;
    int          hold;
    logic        never;
    logic [63:0] exp_res;
    logic        exp_tmo;
    int          exp_k;
  } vec_t;

  vec_t tbl[7];

  initial begin : main
    int k2, aerr2;
    logic [3:0] e2;
    tbl[0] = '{8'h00, 8'h08, 0, 1'b0, 64'd84,          1'b0, 22};
    tbl[1] = '{8'h20, 8'h28, 0, 1'b0, 64'd17179869184, 1'b0, 22};
    tbl[2] = '{8'h08, 8'h00, 5, 1'b0, 64'd84,          1'b0, 22};
    tbl[3] = '{8'h00, 8'h00, 0, 1'b0, 64'd140,         1'b0, 22};
    tbl[4] = '{8'h08, 8'h28, 0, 1'b0, -64'sd36,        1'b0, 22};
    tbl[5] = '{8'h00, 8'h08, 0, 1'b1, 64'd0,           1'b1, 35};
    tbl[6] = '{8'hFC, 8'h08, 0, 1'b0, 64'd140,         1'b0, 22};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0BAD_0000 | 32'(i);
    for (int i = 0; i < 8; i++) begin
      mem[i]        = 32'(i);
      mem[8 + i]    = 32'(8 - i);
      mem[8'h20 + i] = 32'h8000_0000;
      mem[8'h28 + i] = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < 4; i++) mem[8'hFC + i] = 32'd5;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {59'd0, cmd_ready, busy, mem_rd_en, acc_start, rsp_valid}, 64'b10000);
    chk("rst_acc_a", 64'(acc_a != '0), 64'd0);
    chk("rst_acc_b", 64'(acc_b != '0), 64'd0);
    chk("rst_rsp", {rsp_result[62:0], rsp_timeout}, 64'd0);
    rst = 1'b0;

    // Spurious done while idle must be ignored
    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    chk("spur_done_idle", {62'd0, busy, rsp_valid}, 64'd0);

    for (int i = 0; i < 7; i++) begin
      never_done = tbl[i].never;
      run_cmd(tbl[i].ba, tbl[i].bb, tbl[i].hold, tbl[i].exp_res, tbl[i].exp_tmo, tbl[i].exp_k);
    end
    never_done = 1'b0;

    // AW=4 address wrap: a from C wraps to 0; b from 3
    aerr2 = 0;
    @(negedge clk);
    cmd_valid2 = 1'b1; cmd_addr_a2 = 4'hC; cmd_addr_b2 = 4'h3;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      cmd_valid2 = 1'b0;
      e2 = (k <= 8) ? 4'(12 + k - 1) : 4'(3 + k - 9);
      if (mem_rd_en2 !== 1'b1 || mem_addr2 !== e2) aerr2++;
    end
    chk("aw4_wrap_addr_errs", 64'(aerr2), 64'd0);
    k2 = 0;
    while (!rsp_valid2 && k2 < 60) begin @(negedge clk); k2++; end
    chk("aw4_timeout_rsp", {62'd0, rsp_valid2, rsp_timeout2}, 64'b11);
    @(negedge clk);

    // Reset asserted during WAIT
    never_done = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr_a = 8'h00; cmd_addr_b = 8'h08;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("in_wait", {62'd0, busy, rsp_valid}, 64'b10);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {59'd0, cmd_ready, busy, mem_rd_en, acc_start, rsp_valid}, 64'b10000);
    chk("midrst_acc", 64'(acc_a != '0 || acc_b != '0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    never_done = 1'b0;
    run_cmd(8'h00, 8'h08, 0, 64'd84, 1'b0, 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
